// File: rtl/scope_pkg.sv
// Shared definitions for the trigger/capture block: FSM state encoding and
// default geometry of the capture buffer.
package scope_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_CAPTURE = 3'd2,
    S_RD      = 3'd3,
    S_SEND    = 3'd4,
    S_WAIT    = 3'd5
  } state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port capture buffer: one write port, one read port with a
// registered (1-cycle) read. No reset on the array so it maps to block RAM.
module capture_ram #(
  parameter int pAddrW = 9,
  parameter int pDataW = 8
) (
  input  logic              iClk,
  input  logic              iWr_En,
  input  logic [pAddrW-1:0] iWr_Addr,
  input  logic [pDataW-1:0] iWr_Data,
  input  logic              iRd_En,
  input  logic [pAddrW-1:0] iRd_Addr,
  output logic [pDataW-1:0] oRd_Data
);

  logic [pDataW-1:0] mem [0:(1<<pAddrW)-1];

  always_ff @(posedge iClk) begin
    if (iWr_En) begin
      mem[iWr_Addr] <= iWr_Data;
    end
    if (iRd_En) begin
      oRd_Data <= mem[iRd_Addr];
    end
  end

endmodule

// File: rtl/trigger_capture.sv
// Edge-triggered sample capture: arm, wait for a level crossing, store
// 2^pAddrW samples starting at the trigger sample, then stream them to a UART.
module trigger_capture
  import scope_pkg::*;
#(
  parameter int pAddrW = ADDR_W_DEF,
  parameter int pDataW = DATA_W_DEF
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic [pDataW-1:0] iData,
  input  logic              iData_Valid,
  input  logic              iArm,
  input  logic              iTrigRising,
  input  logic [pDataW-1:0] iTrigLevel,
  output logic              oTx_DV,
  output logic [7:0]        oTx_Byte,
  input  logic              iTx_Active,
  input  logic              iTx_Done,
  output logic              oBusy,
  output logic              oTriggered,
  output state_t            oDbg_State
);

  localparam logic [pAddrW-1:0] LAST_ADDR = '1;

  // Handshake to uart_tx: oTx_DV is a single-cycle strobe raised only in SEND
  // while iTx_Active=0; the byte is held valid with it. iTx_Done is a one-cycle
  // pulse closing the byte, consumed only in WAIT.

  state_t            state_q, state_d;
  logic [pDataW-1:0] prev_q;
  logic              prev_valid_q;
  logic [pAddrW-1:0] wr_addr_q, rd_addr_q;
  logic              trig_hit, cap_last;
  logic              ram_we, ram_re;
  logic [pAddrW-1:0] ram_wa;
  logic [pDataW-1:0] rd_data;

  // A crossing needs a valid previous sample, so the first sample after arming never fires.
  assign trig_hit = iData_Valid && prev_valid_q &&
                    (iTrigRising ? ((prev_q < iTrigLevel) && (iData >= iTrigLevel))
                                 : ((prev_q > iTrigLevel) && (iData <= iTrigLevel)));
  assign cap_last = iData_Valid && (wr_addr_q == LAST_ADDR);

  assign oDbg_State = state_q;

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (iArm)        state_d = S_ARMED;
      S_ARMED:   if (trig_hit)    state_d = S_CAPTURE;
      S_CAPTURE: if (cap_last)    state_d = S_RD;
      S_RD:                       state_d = S_SEND;
      S_SEND:    if (!iTx_Active) state_d = S_WAIT;
      S_WAIT: begin
        if (iTx_Done) begin
          state_d = (rd_addr_q == LAST_ADDR) ? S_IDLE : S_RD;
        end
      end
      default:                    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    oBusy      = (state_q != S_IDLE);
    oTriggered = 1'b0;
    oTx_DV     = 1'b0;
    oTx_Byte   = '0;
    ram_we     = 1'b0;
    ram_wa     = wr_addr_q;
    ram_re     = 1'b0;
    case (state_q)
      S_ARMED: begin
        // Trigger sample always lands at address 0.
        ram_we = trig_hit;
        ram_wa = '0;
      end
      S_CAPTURE: begin
        oTriggered = 1'b1;
        ram_we     = iData_Valid;
      end
      S_RD: begin
        oTriggered = 1'b1;
        ram_re     = 1'b1;
      end
      S_SEND: begin
        oTriggered = 1'b1;
        if (!iTx_Active) begin
          oTx_DV   = 1'b1;
          oTx_Byte = 8'(rd_data);
        end
      end
      S_WAIT: begin
        oTriggered = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (iArm) prev_valid_q <= 1'b0;
        end
        S_ARMED: begin
          if (iData_Valid) begin
            prev_q       <= iData;
            prev_valid_q <= 1'b1;
          end
          if (trig_hit) wr_addr_q <= pAddrW'(1);
        end
        S_CAPTURE: begin
          if (iData_Valid) wr_addr_q <= wr_addr_q + pAddrW'(1);
          if (cap_last)    rd_addr_q <= '0;
        end
        S_WAIT: begin
          if (iTx_Done && (rd_addr_q != LAST_ADDR)) rd_addr_q <= rd_addr_q + pAddrW'(1);
        end
        default: ;
      endcase
    end
  end

  capture_ram #(
    .pAddrW (pAddrW),
    .pDataW (pDataW)
  ) u_ram (
    .iClk     (iClk),
    .iWr_En   (ram_we),
    .iWr_Addr (ram_wa),
    .iWr_Data (iData),
    .iRd_En   (ram_re),
    .iRd_Addr (rd_addr_q),
    .oRd_Data (rd_data)
  );

endmodule

// File: doc/trigger_capture.md
TRIGGER_CAPTURE -- requirements
Module: trigger_capture

Interface
REQ-001 Parameter pAddrW, default 9, log2 of capture depth (2^pAddrW samples).
REQ-002 Parameter pDataW, default 8, sample width.
REQ-003 iClk  input  1  system clock (100 MHz); the only clock.
REQ-004 iRstN  input  1  reset; synchronous, active-low.
REQ-005 iData  input  pDataW  downsampled ADC sample.
REQ-006 iData_Valid  input  1  one-cycle qualifier for iData.
REQ-007 iArm  input  1  pulse; arms the trigger (honoured in IDLE only).
REQ-008 iTrigRising  input  1  1 = rising-edge trigger, 0 = falling-edge trigger.
REQ-009 iTrigLevel  input  pDataW  trigger threshold, unsigned.
REQ-010 oTx_DV  output  1  one-cycle byte strobe to the UART transmitter.
REQ-011 oTx_Byte  output  8  byte to transmit, valid while oTx_DV=1.
REQ-012 iTx_Active  input  1  UART transmitter busy.
REQ-013 iTx_Done  input  1  UART one-cycle end-of-byte pulse.
REQ-014 oBusy  output  1  high in every state except IDLE.
REQ-015 oTriggered  output  1  high from trigger detection until return to IDLE.

Function
REQ-016 FSM states SHALL be IDLE, ARMED, CAPTURE, RD, SEND and WAIT.
REQ-017 IDLE->ARMED when iArm=1; the previous-sample-valid flag is cleared on entry to ARMED.
REQ-018 In ARMED, each valid sample SHALL update the previous sample; the first valid sample after arming SHALL never trigger.
REQ-019 Rising trigger: prev < iTrigLevel and cur >= iTrigLevel; falling trigger: prev > iTrigLevel and cur <= iTrigLevel; unsigned compare.
REQ-020 On trigger, the triggering sample SHALL be written to address 0, the write address set to 1, oTriggered set, and the FSM SHALL enter CAPTURE.
REQ-021 In CAPTURE, each valid sample SHALL be written at the write address, which then increments; after address 2^pAddrW-1 is written, the read address is set to 0 and the FSM SHALL enter RD.
REQ-022 Samples arriving in RD, SEND or WAIT SHALL be dropped.
REQ-023 RD: the RAM read is issued (1-cycle latency); next cycle SEND.
REQ-024 SEND: if iTx_Active=0, assert oTx_DV for exactly one cycle with oTx_Byte = RAM data, then go to WAIT; otherwise hold in SEND.
REQ-025 WAIT: on iTx_Done, if the read address is 2^pAddrW-1, go to IDLE and clear oTriggered; otherwise increment the read address and go to RD.
REQ-026 Bytes SHALL be sent in capture order, starting with the trigger sample; exactly 2^pAddrW bytes per capture.
REQ-027 iArm outside IDLE SHALL be ignored; iArm and a trigger in the same cycle of ARMED SHALL have no extra effect.
REQ-028 oTx_DV SHALL never be asserted outside SEND and never on two consecutive cycles.
REQ-029 Address counters SHALL be pAddrW bits and wrap naturally; no further write occurs after the last address.

Reset
REQ-030 While iRstN=0 at a rising iClk edge: state=IDLE, oTx_DV=0, oTx_Byte=0, oBusy=0, oTriggered=0, addresses=0, previous-valid flag=0.
REQ-031 Reset mid-capture or mid-dump SHALL abort immediately; RAM contents are not cleared and are undefined to the user.

Structure
REQ-032 Package scope_pkg SHALL hold the FSM state encoding and the default pAddrW/pDataW constants.
REQ-033 Storage SHALL be a sub-module capture_ram: simple dual-port RAM, one write port and one read port, 1-cycle registered read, inferable to iCE40 block RAM.
REQ-034 The block is placed between downsampling (iData/iData_Valid) and uart_tx (i_Tx_DV/i_Tx_Byte/o_Tx_Active/o_Tx_Done).

Verification (pAddrW=4, 16 samples; UART model: Active 10 cycles, then a Done pulse)
REQ-035 Arm; rising trigger with level 0x80; samples 0x10,0x70,0x90,0x91.. -> trigger at 0x90; 16 bytes sent starting 0x90, 0x91.., then oBusy=0.
REQ-036 Falling trigger with level 0x80; samples 0xF0,0x80 -> trigger on 0x80; first byte 0x80.
REQ-037 First valid sample after arming is 0xFF, level 0x80 rising -> no trigger; FSM stays ARMED.
REQ-038 iTx_Active held high for 50 cycles while in SEND -> oTx_DV is held off, then pulses exactly once.
REQ-039 iArm pulsed during CAPTURE and during dump -> ignored; exactly 16 bytes sent.
REQ-040 iRstN=0 after the 5th byte -> next cycle state=IDLE, oTx_DV=0, oBusy=0; a new arm and trigger yields a full 16-byte dump.
